// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline drain buffer.
//   DATA_WIDTH_DEFAULT : default width of a result word
//   SKID_DEFAULT       : register stages between stall_out and the point where
//                        pushes actually stop (two-stage datapath pipeline)
//   drain_entry_t      : stored FIFO entry {co_filter, done, data} at the
//                        default width
//   entry_width()      : width of a stored entry for an arbitrary data width
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int SKID_DEFAULT       = 2;

    typedef struct packed {
        logic                          co_filter;
        logic                          done;
        logic [DATA_WIDTH_DEFAULT-1:0] data;
    } drain_entry_t;

    // Two tag bits ride alongside every data word.
    function automatic int entry_width(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/drain_fifo_mem.sv
// ---------------------------------------------------------------------------
// drain_fifo_mem
// Register-array storage for the drain FIFO: synchronous write, asynchronous
// read so the head entry is visible with zero latency (show-ahead).
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write pointer
//   wdata_i : entry to store
//   raddr_i : read pointer
//   rdata_o : entry at raddr_i (combinational)
// ---------------------------------------------------------------------------
module drain_fifo_mem #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;

    // Storage carries no reset: validity is tracked entirely by the counter.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_drain_buffer.sv
// ---------------------------------------------------------------------------
// pipe_drain_buffer
// Receiving end of the convolution datapath. Buffers result words (with their
// done / co_filter tags) in a circular FIFO, drains them through a
// valid/ready handshake, and raises stall_out early enough that the SKID
// words still in flight always find room.
//
// Ports:
//   clk, rst (sync, active low)
//   push_in, data_in, done_in, co_filter_in : word from last pipeline stage
//   clear_in                                : synchronous flush
//   stall_out                               : to pipeline stall inputs
//   out_valid, out_data, out_done,
//   out_co_filter, out_ready                : show-ahead drain handshake
//   count_out                               : occupancy
//   done_seen                               : sticky, done-tagged word popped
//   ovf_flag, ovf_count                     : only with PIPE_DRAIN_OVF_EN
//
// Build option: define PIPE_DRAIN_OVF_EN to add the dropped-word flag and
// saturating dropped-word counter. FIFO and stall behaviour do not change.
// ---------------------------------------------------------------------------
module pipe_drain_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 8,
    parameter int SKID       = SKID_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     done_in,
    input  logic                     co_filter_in,
    input  logic                     clear_in,
    output logic                     stall_out,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_done,
    output logic                     out_co_filter,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count_out,
`ifdef PIPE_DRAIN_OVF_EN
    output logic                     ovf_flag,
    output logic [7:0]               ovf_count,
`endif
    output logic                     done_seen
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int EW       = entry_width(DATA_WIDTH);
    localparam int STALL_TH = DEPTH - SKID;

    typedef struct packed {
        logic                  co_filter;
        logic                  done;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q;
    logic          done_seen_q;
    logic          push, pop, we;
    entry_t        wr_entry, head;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push      = push_in & ((count_q < CW'(DEPTH)) | pop);
    assign count_d   = count_q + CW'(push) - CW'(pop);

    // Flush and reset cycles must not leave a stray write behind.
    assign we        = push & rst & ~clear_in;
    assign wr_entry  = '{co_filter: co_filter_in, done: done_in, data: data_in};

    drain_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_q     <= 1'b0;
            done_seen_q <= 1'b0;
        end else if (clear_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_q     <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;  // wraps modulo DEPTH
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            // Stall on the projected occupancy so SKID in-flight words fit.
            stall_q <= (count_d >= CW'(STALL_TH));
            if (pop && head.done) done_seen_q <= 1'b1;
        end
    end

    assign stall_out     = stall_q;
    assign out_data      = head.data;
    assign out_done      = head.done;
    assign out_co_filter = head.co_filter;
    assign count_out     = count_q;
    assign done_seen     = done_seen_q;

`ifdef PIPE_DRAIN_OVF_EN
    logic       ovf_flag_q;
    logic [7:0] ovf_count_q;
    logic       drop;

    assign drop = push_in & (count_q == CW'(DEPTH)) & ~pop;

    always_ff @(posedge clk) begin
        if (!rst || clear_in) begin
            ovf_flag_q  <= 1'b0;
            ovf_count_q <= '0;
        end else if (drop) begin
            ovf_flag_q  <= 1'b1;
            if (ovf_count_q != 8'hFF) ovf_count_q <= ovf_count_q + 8'd1;
        end
    end

    assign ovf_flag  = ovf_flag_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_pipe_drain_buffer.sv
module tb_pipe_drain_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_in, done_in, co_filter_in, clear_in, out_ready;
    logic [DW-1:0] data_in;
    logic          stall_out, out_valid, out_done, out_co_filter, done_seen;
    logic [DW-1:0] out_data;
    logic [3:0]    count_out;
`ifdef PIPE_DRAIN_OVF_EN
    logic          ovf_flag;
    logic [7:0]    ovf_count;
`endif

    always #5 clk = ~clk;

    pipe_drain_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_in       (push_in),
        .data_in       (data_in),
        .done_in       (done_in),
        .co_filter_in  (co_filter_in),
        .clear_in      (clear_in),
        .stall_out     (stall_out),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_done      (out_done),
        .out_co_filter (out_co_filter),
        .out_ready     (out_ready),
        .count_out     (count_out),
`ifdef PIPE_DRAIN_OVF_EN
        .ovf_flag      (ovf_flag),
        .ovf_count     (ovf_count),
`endif
        .done_seen     (done_seen)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          dn;
        logic          co;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   st_m  = 0;
    bit   ds_m  = 0;
    bit   ovf_m = 0;
    int   ovc_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count_out), 32'(q.size()));
        chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, ".stall"}, 32'(stall_out), 32'(st_m));
        chk({tag, ".done_seen"}, 32'(done_seen), 32'(ds_m));
`ifdef PIPE_DRAIN_OVF_EN
        chk({tag, ".ovf_flag"}, 32'(ovf_flag), 32'(ovf_m));
        chk({tag, ".ovf_count"}, 32'(ovf_count), 32'(ovc_m));
`endif
    endtask

    // One clock: drive inputs, check the head if it is being popped, advance
    // the reference model, then compare the registered state after the edge.
    task automatic cyc(input string tag, input bit p, input logic [DW-1:0] d,
                       input bit dn, input bit co, input bit rdy, input bit clr);
        bit   pop_m, acc;
        ent_t e;
        push_in = p; data_in = d; done_in = dn; co_filter_in = co;
        out_ready = rdy; clear_in = clr;
        #1;
        pop_m = rdy && (q.size() != 0);
        if (pop_m) begin
            e = q[0];
            chk({tag, ".head_data"}, 32'(out_data), 32'(e.d));
            chk({tag, ".head_done"}, 32'(out_done), 32'(e.dn));
            chk({tag, ".head_cof"}, 32'(out_co_filter), 32'(e.co));
        end
        if (clr) begin
            q.delete();
            st_m = 0; ds_m = 0; ovf_m = 0; ovc_m = 0;
        end else begin
            acc = p && ((q.size() < DEPTH) || pop_m);
            if (p && q.size() == DEPTH && !pop_m) begin
                ovf_m = 1;
                if (ovc_m < 255) ovc_m++;
            end
            if (pop_m) begin
                if (q[0].dn) ds_m = 1;
                void'(q.pop_front());
            end
            if (acc) begin
                e.d = d; e.dn = dn; e.co = co;
                q.push_back(e);
            end
            st_m = (q.size() >= DEPTH - SKID);
        end
        @(posedge clk); #1;
        chk_state(tag);
    endtask

    initial begin
        rst = 1'b0; push_in = 0; data_in = '0; done_in = 0; co_filter_in = 0;
        clear_in = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_state("reset");
        cyc("idle", 0, 8'h00, 0, 0, 0, 0);

        // Fill to the stall threshold, then the two skid words.
        for (int i = 1; i <= 6; i++) cyc("fill", 1, 8'(i), 0, 0, 0, 0);
        chk("stall_after_6", 32'(stall_out), 32'd1);
        cyc("fill7", 1, 8'h07, 0, 0, 0, 0);
        cyc("fill8", 1, 8'h08, 0, 0, 0, 0);
        chk("full_count", 32'(count_out), 32'd8);
        for (int i = 0; i < 8; i++) cyc("drain", 0, 8'h00, 0, 0, 1, 0);
        cyc("empty", 0, 8'h00, 0, 0, 1, 0);

        // Full with simultaneous push/pop; pointers wrap again.
        for (int i = 0; i < 8; i++) cyc("refill", 1, 8'(8'h20 + i), 0, 0, 0, 0);
        cyc("pushpop_full", 1, 8'hAA, 0, 0, 1, 0);
        chk("pushpop_count", 32'(count_out), 32'd8);
        for (int i = 0; i < 8; i++) cyc("drain_aa", 0, 8'h00, 0, 0, 1, 0);

        // No bypass: push into empty with ready high appears next cycle.
        cyc("nobypass", 1, 8'h55, 0, 0, 1, 0);
        cyc("nobypass_pop", 0, 8'h00, 0, 0, 1, 0);

        // Tags and sticky done_seen.
        cyc("tag_cof", 1, 8'h10, 0, 1, 0, 0);
        cyc("tag_done", 1, 8'h11, 1, 0, 0, 0);
        cyc("pop_cof", 0, 8'h00, 0, 0, 1, 0);
        chk("ds_before", 32'(done_seen), 32'd0);
        cyc("pop_done", 0, 8'h00, 0, 0, 1, 0);
        chk("ds_after", 32'(done_seen), 32'd1);
        cyc("ds_sticky", 0, 8'h00, 0, 0, 0, 0);

        // clear at count=5 with a push in the same cycle.
        for (int i = 0; i < 5; i++) cyc("prefill", 1, 8'(8'h30 + i), 0, 0, 0, 0);
        cyc("clear", 1, 8'hEE, 0, 0, 0, 1);
        chk("clear_count", 32'(count_out), 32'd0);
        cyc("after_clear", 1, 8'h77, 0, 0, 0, 0);
        cyc("after_clear_pop", 0, 8'h00, 0, 0, 1, 0);

        // Overflow: full, no pop, three extra words dropped.
        for (int i = 0; i < 8; i++) cyc("ovf_fill", 1, 8'(8'h40 + i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("ovf_push", 1, 8'(8'hF0 + i), 0, 0, 0, 0);
`ifdef PIPE_DRAIN_OVF_EN
        chk("ovf_count3", 32'(ovf_count), 32'd3);
`endif
        for (int i = 0; i < 8; i++) cyc("ovf_drain", 0, 8'h00, 0, 0, 1, 0);
        cyc("ovf_clear", 0, 8'h00, 0, 0, 0, 1);

        // Reset while words are buffered discards them.
        for (int i = 0; i < 3; i++) cyc("pre_rst", 1, 8'(8'h60 + i), 1, 0, 0, 0);
        cyc("pre_rst_pop", 0, 8'h00, 0, 0, 1, 0);
        push_in = 1; out_ready = 1; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; push_in = 0; out_ready = 0;
        q.delete(); st_m = 0; ds_m = 0; ovf_m = 0; ovc_m = 0;
        chk_state("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_drain_buffer.md
Name: pipe_drain_buffer

Overview:
- Receiving end of the convolution datapath pipeline registers, and the source of the `stall` signal that those registers consume.
- Accepts result words, with their `done` and `co_filter` tags, from the last pipeline stage and stores them in a circular FIFO.
- Drains the FIFO to the output/memory writer through a valid/ready handshake.
- Asserts `stall_out` back up the pipeline early enough that in-flight words are never lost.

Parameters:
- DATA_WIDTH, 8: width of a result word.
- DEPTH, 8: FIFO entries; must be a power of 2 and ≥ SKID+2.
- SKID, 2: number of pipeline register stages between `stall_out` and the point where pushes actually stop.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (sampled on the clk rising edge; 0 = reset).
- push_in  in  1  word valid from the last pipeline stage.
- data_in  in  DATA_WIDTH  result word.
- done_in  in  1  tag: last word of the whole operation.
- co_filter_in  in  1  tag: last word of the current filter.
- clear_in  in  1  synchronous flush.
- stall_out  out  1  to the pipeline `stall_in` inputs.
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_WIDTH  head word.
- out_done  out  1  head `done` tag.
- out_co_filter  out  1  head `co_filter` tag.
- out_ready  in  1  downstream accepts the head.
- count_out  out  $clog2(DEPTH)+1  occupancy.
- done_seen  out  1  sticky; set when a `done`-tagged word is popped.

Behaviour:
- Reset (rst=0 at an edge) sets: pointers=0, count=0, stall_out=0, done_seen=0. Because the FIFO is then empty, out_valid=0 and all out_* outputs are don't-care.
- Storage: entry = {co_filter, done, data}, width DATA_WIDTH+2. Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Outputs: out_valid = (count≠0), combinational from count. out_data, out_done and out_co_filter are a combinational read of mem[rd_ptr], giving zero-latency show-ahead.
- pop = out_valid & out_ready.
- push = push_in & (count<DEPTH | pop).
  - Pushing into a full FIFO in the same cycle as a pop is legal.
  - push_in=1 while full with no pop is an overflow: the word is dropped and the FIFO state is unchanged.
- count_next = count + push − pop. Push and pop together leave count unchanged.
- stall_out is registered: stall_out <= (count_next ≥ DEPTH−SKID).
  - The pipeline then delivers at most SKID further words, so correct upstream use guarantees no overflow.
  - stall_out deasserts the cycle after count_next falls below DEPTH−SKID.
- Write latency is 1 cycle: a word pushed at edge N is visible on out_data after edge N, provided the FIFO was empty.
- done_seen: set on a pop whose out_done=1; cleared only by rst or clear_in.
- clear_in=1 at an edge:
  - pointers=0, count=0, stall_out=0, done_seen=0.
  - Any push or pop in that same cycle is ignored.
  - clear_in has priority over everything except rst.
- Empty with push_in=1 and out_ready=1: there is no bypass. The word appears one cycle later.
- Reset during an active transfer: all state is discarded, and buffered words are lost by design.

Optional Feature:
- Macro: PIPE_DRAIN_OVF_EN.
- Defined:
  - Adds output `ovf_flag` (1 bit), reset 0 and cleared by clear_in.
  - Set sticky when push_in=1, count==DEPTH and pop=0.
  - Adds an 8-bit saturating `ovf_count` output that counts dropped words.
- Undefined: neither port exists and the dropped-word logic is absent.
- FIFO and stall behaviour are identical in both builds.

Decomposition:
- Shared package `pipe_pkg`, holding:
  - the entry struct typedef `drain_entry_t`, as {co_filter, done, data} parameterised via DATA_WIDTH localparam usage;
  - the `SKID_DEFAULT` constant = 2, matching the two-stage pipeline.
- One natural sub-module, `drain_fifo_mem`: dual-pointer register array with synchronous write and asynchronous read. Counter, stall and tag logic stay in the top level.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 → stall_out=0, out_valid=0, count_out=0, done_seen=0.
- Fill with out_ready=0, DEPTH=8, SKID=2: push 0x01..0x06 on consecutive cycles → stall_out rises the cycle after the 6th push. Then push 2 more words, 0x07 and 0x08 → count_out=8, no loss. Then drain with out_ready=1 → 0x01..0x08 in order.
- Simultaneous push/pop at full: count=8, push 0xAA with out_ready=1 → count stays 8; 0xAA is emitted 8 pops later; the wrap-around of both pointers is checked.
- Tags: push 0x10 with co_filter=1, then 0x11 with done=1 → out_co_filter=1 on 0x10 and out_done=1 on 0x11; done_seen=1 the cycle after 0x11 is popped.
- clear_in mid-fill at count=5, with push_in=1 the same cycle → next cycle count_out=0, out_valid=0, stall_out=0, done_seen=0; the pushed word is absent.
- With PIPE_DRAIN_OVF_EN: full, out_ready=0, push 3 words → ovf_flag=1, ovf_count=3, FIFO contents unchanged; clear_in → both 0.
